// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants and types for the transmit lane serializer.
// The COM value is the same symbol the receive lane looks for.
package paralelo_serial_tx_pkg;

   localparam logic [7:0] COM_SYMBOL        = 8'hBC;
   localparam int         TRAIN_COM_DEFAULT = 4;

   typedef enum logic {
      TRAIN = 1'b0,
      RUN   = 1'b1
   } tx_state_e;

   // Decision taken at a byte boundary once the lane is carrying data or idle fill
   typedef struct packed {
      logic [7:0] byte_val;
      logic       take_hold;
      logic [1:0] idx_next;
      logic       wbusy_next;
   } byte_pick_t;

   // Byte idx of a word, byte 3 being bits 31:24
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Word handshake between the striping logic (master) and one serializer lane (slave).
interface paralelo_serial_tx_if;

   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;

   modport master (
      output data_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out
   );

endinterface

// File: rtl/paralelo_serial_tx.sv
// Transmit lane serializer: 32-bit words in, one MSB-first byte-framed bitstream out.
// After reset the lane sends TRAIN_COM COM symbols, then carries words, filling
// idle byte slots with COM. A one-word hold register lets the next word be
// queued while the current one is shifting, so back-to-back words leave with
// no COM between them.
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
#(
   parameter logic [7:0] COM       = COM_SYMBOL,
   parameter int         TRAIN_COM = TRAIN_COM_DEFAULT
) (
   input  logic                 clk_32f,
   input  logic                 reset,
   paralelo_serial_tx_if.slave  tx,
   output logic                 data_paralelo_serial,
   output logic                 active_paralelo_serial,
   output logic                 sym_start
);

   localparam logic [3:0] LAST_TRAIN = 4'(TRAIN_COM - 1);

   tx_state_e   state;
   logic [7:0]  sh;
   logic [2:0]  bit_cnt;
   logic [3:0]  com_cnt;
   logic [31:0] wbuf;
   logic [1:0]  byte_idx;
   logic        wbusy;
   logic [31:0] hbuf;
   logic        hfull;

   logic        boundary;
   logic        load_run;
   logic        accept;
   byte_pick_t  pick;

   assign boundary = (bit_cnt == 3'd7);

   // The boundary that ends training already loads its byte by the data rules
   assign load_run = boundary && ((state == RUN) || (com_cnt == LAST_TRAIN));

   // Accept only into an empty hold register, so accept and consume never coincide
   assign accept       = tx.valid_in && !hfull;
   assign tx.ready_out = !hfull;

   assign data_paralelo_serial = sh[7];
   assign sym_start            = (bit_cnt == 3'd0);

   // Choose the byte for the next slot: continue the current word, chain the held word
   // in on its last byte so there is no gap, start a held word, or send idle COM
   always_comb begin
      pick.byte_val   = COM;
      pick.take_hold  = 1'b0;
      pick.idx_next   = byte_idx;
      pick.wbusy_next = wbusy;
      if (wbusy) begin
         pick.byte_val = word_byte(wbuf, 2'd3 - byte_idx);
         if (byte_idx != 2'd3) begin
            pick.idx_next = byte_idx + 2'd1;
         end else if (hfull) begin
            pick.take_hold = 1'b1;
            pick.idx_next  = 2'd0;
         end else begin
            pick.wbusy_next = 1'b0;
         end
      end else if (hfull) begin
         pick.byte_val   = hbuf[31:24];
         pick.take_hold  = 1'b1;
         pick.idx_next   = 2'd1;
         pick.wbusy_next = 1'b1;
      end
   end

   // Shifter, training FSM, word buffer and hold register, all cleared by reset
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state                  <= TRAIN;
         sh                     <= COM;
         bit_cnt                <= 3'd0;
         com_cnt                <= 4'd0;
         active_paralelo_serial <= 1'b0;
         wbuf                   <= 32'd0;
         byte_idx               <= 2'd0;
         wbusy                  <= 1'b0;
         hbuf                   <= 32'd0;
         hfull                  <= 1'b0;
      end else begin
         if (!boundary) begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
         end else begin
            bit_cnt <= 3'd0;
            if (load_run) begin
               sh       <= pick.byte_val;
               byte_idx <= pick.idx_next;
               wbusy    <= pick.wbusy_next;
               if (pick.take_hold) begin
                  wbuf <= hbuf;
               end
            end else begin
               sh <= COM;
            end
            case (state)
               TRAIN: begin
                  com_cnt <= com_cnt + 4'd1;
                  if (com_cnt == LAST_TRAIN) begin
                     state                  <= RUN;
                     active_paralelo_serial <= 1'b1;
                  end
               end
               RUN: begin
                  state <= RUN;
               end
               default: begin
                  state <= TRAIN;
               end
            endcase
         end
         if (accept) begin
            hbuf  <= tx.data_in;
            hfull <= 1'b1;
         end else if (load_run && pick.take_hold) begin
            hfull <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: byte-slot reference model checked every cycle,
// a table of idle-line expectations, hand sequences for the corner cases, and a
// random traffic phase. A second instance uses TRAIN_COM=1.
module tb_paralelo_serial_tx;

   localparam int         TRAIN_N = 4;
   localparam logic [7:0] COMV    = 8'hBC;

   logic clk;
   logic rst;
   logic line0, sym0, act0;
   logic line1, sym1, act1;

   paralelo_serial_tx_if tx_if ();
   paralelo_serial_tx_if tx1_if ();

   paralelo_serial_tx #(.COM(8'hBC), .TRAIN_COM(TRAIN_N)) dut (
      .clk_32f                (clk),
      .reset                  (rst),
      .tx                     (tx_if),
      .data_paralelo_serial   (line0),
      .active_paralelo_serial (act0),
      .sym_start              (sym0)
   );

   paralelo_serial_tx #(.COM(8'hBC), .TRAIN_COM(1)) dut1 (
      .clk_32f                (clk),
      .reset                  (rst),
      .tx                     (tx1_if),
      .data_paralelo_serial   (line1),
      .active_paralelo_serial (act1),
      .sym_start              (sym1)
   );

   // Bit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: one byte slot every 8 cycles, a queue of bytes still to send
   // for the word in flight, and one held word
   int          m_cycle;
   logic [7:0]  m_byte;
   logic [7:0]  m_inflight[$];
   logic        m_held_full;
   logic [31:0] m_held;
   logic        last_acc;

   logic [7:0]  byte_log[$];
   logic [7:0]  cur_bits;
   logic [7:0]  pat[$];

   typedef struct {
      int   cyc;
      logic line;
      logic sym;
      logic act;
      logic rdy;
   } idle_vec_t;
   idle_vec_t idle_tbl[10];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic modelReset();
      m_cycle     = 0;
      m_byte      = COMV;
      m_inflight  = {};
      m_held_full = 1'b0;
      m_held      = 32'd0;
   endtask

   task automatic pushWord(input logic [31:0] w);
      m_inflight.push_back(w[31:24]);
      m_inflight.push_back(w[23:16]);
      m_inflight.push_back(w[15:8]);
      m_inflight.push_back(w[7:0]);
   endtask

   task automatic modelAdvance(input logic acc, input logic [31:0] d);
      if (m_cycle % 8 == 7) begin
         if (m_cycle / 8 + 1 < TRAIN_N) begin
            m_byte = COMV;
         end else if (m_inflight.size() != 0) begin
            m_byte = m_inflight.pop_front();
            if (m_inflight.size() == 0 && m_held_full) begin
               pushWord(m_held);
               m_held_full = 1'b0;
            end
         end else if (m_held_full) begin
            pushWord(m_held);
            m_held_full = 1'b0;
            m_byte = m_inflight.pop_front();
         end else begin
            m_byte = COMV;
         end
      end
      if (acc) begin
         m_held      = d;
         m_held_full = 1'b1;
      end
      m_cycle++;
   endtask

   // Compare the main instance against the model and log the received bytes
   task automatic checkOutput();
      int pos;
      pos = m_cycle % 8;
      checkVal("line",   32'(line0), 32'(m_byte[7-pos]));
      checkVal("sym",    32'(sym0), 32'(pos == 0));
      checkVal("active", 32'(act0), 32'(m_cycle >= 8 * TRAIN_N));
      checkVal("ready",  32'(tx_if.ready_out), 32'(!m_held_full));
      cur_bits = {cur_bits[6:0], line0};
      if (pos == 7) byte_log.push_back(cur_bits);
   endtask

   // Drive one cycle of inputs, advance the model on the edge, check half a cycle later
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
      logic acc;
      rst             = r;
      tx_if.valid_in  = v;
      tx_if.data_in   = d;
      acc             = v && !m_held_full && !r;
      last_acc        = acc;
      @(posedge clk);
      if (r) modelReset();
      else   modelAdvance(acc, d);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic sendWord(input logic [31:0] w, input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         applyStimulus(1'b1, w, 1'b0);
         got = last_acc;
      end
      checkVal(name, 32'(got), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0);
   endtask

   function automatic int findSeq(input int from);
      logic ok;
      for (int i = from; i + pat.size() <= byte_log.size(); i++) begin
         ok = 1'b1;
         for (int j = 0; j < pat.size(); j++) begin
            if (byte_log[i+j] !== pat[j]) ok = 1'b0;
         end
         if (ok) return i;
      end
      return -1;
   endfunction

   // Safety net against a hung run
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          mark;
      int          idx;
      int          stall_n;
      logic        got;
      logic [7:0]  d1_bits;
      logic [31:0] w;
      logic [7:0]  tail_byte;
      logic        r;

      idle_tbl[0] = '{0,  1'b1, 1'b1, 1'b0, 1'b1};
      idle_tbl[1] = '{1,  1'b0, 1'b0, 1'b0, 1'b1};
      idle_tbl[2] = '{2,  1'b1, 1'b0, 1'b0, 1'b1};
      idle_tbl[3] = '{6,  1'b0, 1'b0, 1'b0, 1'b1};
      idle_tbl[4] = '{8,  1'b1, 1'b1, 1'b0, 1'b1};
      idle_tbl[5] = '{31, 1'b0, 1'b0, 1'b0, 1'b1};
      idle_tbl[6] = '{32, 1'b1, 1'b1, 1'b1, 1'b1};
      idle_tbl[7] = '{35, 1'b1, 1'b0, 1'b1, 1'b1};
      idle_tbl[8] = '{39, 1'b0, 1'b0, 1'b1, 1'b1};
      idle_tbl[9] = '{63, 1'b0, 1'b0, 1'b1, 1'b1};

      cur_bits        = 8'd0;
      d1_bits         = 8'd0;
      tx_if.valid_in  = 1'b0;
      tx_if.data_in   = 32'd0;
      tx1_if.valid_in = 1'b0;
      tx1_if.data_in  = 32'd0;
      modelReset();

      // Reset, then idle line; the TRAIN_COM=1 lane takes a word at cycle 0
      repeat (2) applyStimulus(1'b0, 32'd0, 1'b1);
      tx1_if.valid_in = 1'b1;
      tx1_if.data_in  = 32'h5A3C1234;
      for (int c = 0; c < 64; c++) begin
         for (int k = 0; k < 10; k++) begin
            if (idle_tbl[k].cyc == c) begin
               checkVal($sformatf("idle_line_c%0d", c),   32'(line0), 32'(idle_tbl[k].line));
               checkVal($sformatf("idle_sym_c%0d", c),    32'(sym0), 32'(idle_tbl[k].sym));
               checkVal($sformatf("idle_active_c%0d", c), 32'(act0), 32'(idle_tbl[k].act));
               checkVal($sformatf("idle_ready_c%0d", c),  32'(tx_if.ready_out), 32'(idle_tbl[k].rdy));
            end
         end
         if (c == 1) checkVal("t1_ready_c1", 32'(tx1_if.ready_out), 32'd0);
         if (c == 7) checkVal("t1_active_c7", 32'(act1), 32'd0);
         if (c == 8) checkVal("t1_active_c8", 32'(act1), 32'd1);
         if (c == 8) checkVal("t1_ready_c8", 32'(tx1_if.ready_out), 32'd1);
         if (c >= 8 && c < 16) d1_bits = {d1_bits[6:0], line1};
         if (c == 16) checkVal("t1_first_byte", 32'(d1_bits), 32'h5A);
         applyStimulus(1'b0, 32'd0, 1'b0);
         if (c == 0) tx1_if.valid_in = 1'b0;
      end

      // Word presented at cycle 5 during training
      repeat (2) applyStimulus(1'b0, 32'd0, 1'b1);
      w = 32'd0;
      tail_byte = 8'd0;
      for (int c = 0; c < 72; c++) begin
         if (c == 5)  checkVal("deadbeef_ready_c5", 32'(tx_if.ready_out), 32'd1);
         if (c == 6)  checkVal("deadbeef_ready_c6", 32'(tx_if.ready_out), 32'd0);
         if (c == 31) checkVal("deadbeef_active_c31", 32'(act0), 32'd0);
         if (c == 32) checkVal("deadbeef_active_c32", 32'(act0), 32'd1);
         if (c >= 32 && c < 64) w = {w[30:0], line0};
         if (c >= 64) tail_byte = {tail_byte[6:0], line0};
         applyStimulus(c == 5, 32'hDEADBEEF, 1'b0);
      end
      checkVal("deadbeef_word", w, 32'hDEADBEEF);
      checkVal("deadbeef_tail", 32'(tail_byte), 32'hBC);

      // Back-to-back words with valid held high
      mark = byte_log.size();
      sendWord(32'h01234567, "b2b_accept_a");
      sendWord(32'h89ABCDEF, "b2b_accept_b");
      idle(80);
      pat = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      idx = findSeq(mark);
      checkVal("b2b_contiguous", 32'(idx >= 0), 32'd1);

      // Stalled valid: data changes while ready is low, only the value at ready is taken
      mark = byte_log.size();
      sendWord(32'h0A0B0C0D, "stall_accept_w1");
      sendWord(32'h1A1B1C1D, "stall_accept_w2");
      got = 1'b0;
      stall_n = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         applyStimulus(1'b1, (n < 20) ? 32'h77665544 : 32'h33221100, 1'b0);
         got = last_acc;
         stall_n = n;
      end
      checkVal("stall_accept_w3", 32'(got), 32'd1);
      checkVal("stall_length", 32'(stall_n >= 20), 32'd1);
      idle(120);
      pat = {8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1C, 8'h1D,
             8'h33, 8'h22, 8'h11, 8'h00};
      idx = findSeq(mark);
      checkVal("stall_sequence", 32'(idx >= 0), 32'd1);
      pat = {8'h77, 8'h66, 8'h55, 8'h44};
      idx = findSeq(mark);
      checkVal("stall_no_stale", 32'(idx < 0), 32'd1);

      // Reset while the third byte of a word is on the line
      mark = byte_log.size();
      sendWord(32'hCAFEF00D, "rst_accept");
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
         got = (byte_log.size() > mark) && (byte_log[byte_log.size()-1] == 8'hFE);
      end
      checkVal("rst_reached_byte2", 32'(got), 32'd1);
      idle(2);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkVal("rst_line",   32'(line0), 32'd1);
      checkVal("rst_sym",    32'(sym0), 32'd1);
      checkVal("rst_active", 32'(act0), 32'd0);
      checkVal("rst_ready",  32'(tx_if.ready_out), 32'd1);
      mark = byte_log.size();
      idle(48);
      checkVal("rst_log_len", 32'(byte_log.size() >= mark + 5), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (mark + i < byte_log.size())
            checkVal($sformatf("rst_com_%0d", i), 32'(byte_log[mark+i]), 32'hBC);
      end

      // Random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 299) == 0);
         applyStimulus($urandom_range(0, 2) == 0, $urandom, r);
      end
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
